intr_entry_seq: RTL

Interrupt entry/return sequencer sitting directly downstream of the interrupt system, inside the control unit. It consumes the arbitrated `excepCode` and `intrEntryAddr`, then flushes and drains the pipeline. It saves the return context into SRR0/SRR1, clears the protection bits of the MSR, redirects fetch to the vector, and finally returns `ack` so the interrupt system retires the winning request. It also executes `rfi`, restoring MSR and PC from SRR1/SRR0.

---
 rtl/intr_pkg.sv | 40 ++++
 rtl/intr_entry_seq_if.sv | 40 ++++
 rtl/intr_msr_mask.sv | 17 +
 rtl/intr_entry_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared interrupt definitions: exception codes, MSR bit positions, entry-sequencer state encoding.
// MSR bit indices use big-endian numbering (bit 0 = MSB), matching the [0:31] buses.
package intr_pkg;

    localparam int EXC_W = 4;

    localparam logic [EXC_W-1:0] EXC_NONE = 4'd0;
    localparam logic [EXC_W-1:0] EXC_DSI  = 4'd2;
    localparam logic [EXC_W-1:0] EXC_ISI  = 4'd3;
    localparam logic [EXC_W-1:0] EXC_DEV0 = 4'd4;
    localparam logic [EXC_W-1:0] EXC_PROG = 4'd6;
    localparam logic [EXC_W-1:0] EXC_SC   = 4'd8;
    localparam logic [EXC_W-1:0] EXC_DEV1 = 4'd10;
    localparam logic [EXC_W-1:0] EXC_DTLB = 4'd13;
    localparam logic [EXC_W-1:0] EXC_ITLB = 4'd14;

    localparam int MSR_EE = 16;
    localparam int MSR_PR = 17;
    localparam int MSR_IS = 26;
    localparam int MSR_DS = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_VECTOR,
        ST_ACK,
        ST_RFI
    } state_t;

    // Faults re-execute the instruction; traps and device interrupts resume after it.
    function automatic logic srr0_takes_next(input logic [EXC_W-1:0] code);
        case (code)
            EXC_DSI, EXC_ISI, EXC_PROG, EXC_DTLB, EXC_ITLB: return 1'b0;
            EXC_SC, EXC_DEV0, EXC_DEV1:                     return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/intr_entry_seq_if.sv
// Interrupt-system/pipeline side of the entry sequencer; master = sequencer, slave = environment.
interface intr_entry_seq_if #(parameter int EXC_W = intr_pkg::EXC_W);

    logic [EXC_W-1:0] excepCode;
    logic [0:31]      intrEntryAddr;
    logic [0:31]      pc_cur;
    logic [0:31]      pc_next;
    logic             pipe_empty;
    logic [0:31]      MSR;
    logic [0:31]      SRR0;
    logic [0:31]      SRR1;
    logic             rfi_req;

    logic             stall;
    logic             flush;
    logic             srr0_wr;
    logic             srr1_wr;
    logic [0:31]      srr0_wd;
    logic [0:31]      srr1_wd;
    logic             msr_wr;
    logic [0:31]      msr_wd;
    logic             npc_wr;
    logic [0:31]      npc;
    logic             ack;

    modport master (
        input  excepCode, intrEntryAddr, pc_cur, pc_next, pipe_empty,
               MSR, SRR0, SRR1, rfi_req,
        output stall, flush, srr0_wr, srr1_wr, srr0_wd, srr1_wd,
               msr_wr, msr_wd, npc_wr, npc, ack
    );

    modport slave (
        output excepCode, intrEntryAddr, pc_cur, pc_next, pipe_empty,
               MSR, SRR0, SRR1, rfi_req,
        input  stall, flush, srr0_wr, srr1_wr, srr0_wd, srr1_wd,
               msr_wr, msr_wd, npc_wr, npc, ack
    );

endinterface

// File: rtl/intr_msr_mask.sv
// Entry MSR value: clears EE, PR, IS, DS and keeps every other bit. Combinational, no backpressure.
module intr_msr_mask
    import intr_pkg::*;
(
    input  logic [0:31] msr,
    output logic [0:31] msr_masked
);

    always_comb begin
        msr_masked         = msr;
        msr_masked[MSR_EE] = 1'b0;
        msr_masked[MSR_PR] = 1'b0;
        msr_masked[MSR_IS] = 1'b0;
        msr_masked[MSR_DS] = 1'b0;
    end

endmodule

// File: rtl/intr_entry_seq.sv
// Interrupt entry (drain, save SRRs, mask MSR, vector, ack) and rfi return sequencer.
// Entry takes 4 cycles plus one per cycle without pipe_empty; rfi takes 1; stall held outside IDLE.
module intr_entry_seq
    import intr_pkg::*;
#(
    parameter int EXC_W = intr_pkg::EXC_W
) (
    input  logic              clk,
    input  logic              rst,
    intr_entry_seq_if.master  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [EXC_W-1:0] code_q;
    logic [0:31]      pc_cur_q;
    logic [0:31]      pc_next_q;
    // Holds the vector address on entry, or SRR0 on rfi.
    logic [0:31]      tgt_q;
    // Holds MSR on entry, or SRR1 on rfi.
    logic [0:31]      msr_q;
    logic [0:31]      msr_entry;

    logic             stall;
    logic             flush;
    logic             srr0_wr;
    logic             srr1_wr;
    logic [0:31]      srr0_wd;
    logic [0:31]      srr1_wd;
    logic             msr_wr;
    logic [0:31]      msr_wd;
    logic             npc_wr;
    logic [0:31]      npc;
    logic             ack;

    intr_msr_mask u_msr_mask (
        .msr        (msr_q),
        .msr_masked (msr_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            pc_cur_q  <= '0;
            pc_next_q <= '0;
            tgt_q     <= '0;
            msr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (bus.excepCode != EXC_NONE) begin
                    code_q    <= bus.excepCode;
                    pc_cur_q  <= bus.pc_cur;
                    pc_next_q <= bus.pc_next;
                    tgt_q     <= bus.intrEntryAddr;
                    msr_q     <= bus.MSR;
                end else if (bus.rfi_req) begin
                    tgt_q <= bus.SRR0;
                    msr_q <= bus.SRR1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        srr0_wr = 1'b0;
        srr1_wr = 1'b0;
        srr0_wd = '0;
        srr1_wd = '0;
        msr_wr  = 1'b0;
        msr_wd  = '0;
        npc_wr  = 1'b0;
        npc     = '0;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous rfi is flushed by the entry, so it is simply dropped.
                if (bus.excepCode != EXC_NONE) state_d = ST_DRAIN;
                else if (bus.rfi_req)          state_d = ST_RFI;
            end
            ST_DRAIN: begin
                stall = 1'b1;
                flush = 1'b1;
                if (bus.pipe_empty) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                stall   = 1'b1;
                srr0_wr = 1'b1;
                srr1_wr = 1'b1;
                msr_wr  = 1'b1;
                srr0_wd = srr0_takes_next(code_q) ? pc_next_q : pc_cur_q;
                srr1_wd = msr_q;
                msr_wd  = msr_entry;
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                stall   = 1'b1;
                npc_wr  = 1'b1;
                npc     = tgt_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                stall   = 1'b1;
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RFI: begin
                stall   = 1'b1;
                flush   = 1'b1;
                msr_wr  = 1'b1;
                msr_wd  = msr_q;
                npc_wr  = 1'b1;
                npc     = tgt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.stall   = stall;
    assign bus.flush   = flush;
    assign bus.srr0_wr = srr0_wr;
    assign bus.srr1_wr = srr1_wr;
    assign bus.srr0_wd = srr0_wd;
    assign bus.srr1_wd = srr1_wd;
    assign bus.msr_wr  = msr_wr;
    assign bus.msr_wd  = msr_wd;
    assign bus.npc_wr  = npc_wr;
    assign bus.npc     = npc;
    assign bus.ack     = ack;

endmodule
